spi_reg_bank: RTL

SPI-clock-domain register bank that consumes the serial bit stream from the SPI slave front end and serves register reads back over MISO. It runs entirely on the mode-adjusted SPI clock w_SPI_Clk. It parses a command byte followed by a burst of data bytes, writes or reads an internal 16-address map with address auto-increment, and exposes the writable registers as static control outputs to the FPGA fabric.

---
 rtl/spi_reg_bank.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI-clock-domain register bank: command byte + data burst, 16-address map with auto-increment,
// RW registers exposed as static control outputs, reads served MSB-first over MISO.
module spi_reg_bank #(
    parameter int          NUM_RW    = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [7:0]  ID_VAL    = 8'hA5
) (
    input  logic        w_SPI_Clk,
    input  logic        i_Rst_L,
    input  logic        i_SPI_CS_n,
    input  logic        i_SPI_MOSI,
    input  logic [7:0]  i_Status,
    output logic        o_SPI_MISO,
    output logic [63:0] o_Regs,
    output logic        o_Wr_Strobe,
    output logic [3:0]  o_Wr_Addr
);

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic [4:0] NUM_RW_W = 5'(NUM_RW);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [3:0]  addr_q;
    logic [6:0]  shift_q;
    logic [6:0]  tx_q;
    logic        miso_q;
    logic        strobe_q;
    logic [3:0]  wr_addr_q;

    logic        byte_done_s;
    logic [7:0]  rx_byte_s;
    logic        wr_en_s;
    logic [3:0]  rd_addr_s;
    logic [7:0]  rd_val_s;
    logic [7:0]  regs_s [8];

    assign byte_done_s = (cnt_q == 3'd7);
    assign rx_byte_s   = {shift_q, i_SPI_MOSI};
    assign wr_en_s     = !i_SPI_CS_n && (state_q == ST_WRITE) && byte_done_s
                         && ({1'b0, addr_q} < NUM_RW_W);

    // Address whose value gets loaded into the MISO shifter on this edge
    always_comb begin
        if (state_q == ST_CMD) begin
            rd_addr_s = rx_byte_s[3:0];
        end else begin
            rd_addr_s = addr_q + 4'd1;
        end
    end

    // Read map decode; unimplemented RW slots already read back as zero
    always_comb begin
        rd_val_s = 8'h00;
        if (!rd_addr_s[3]) begin
            rd_val_s = regs_s[rd_addr_s[2:0]];
        end else begin
            case (rd_addr_s[2:0])
                3'd0:    rd_val_s = i_Status;
                3'd1:    rd_val_s = ID_VAL;
                default: rd_val_s = 8'h00;
            endcase
        end
    end

    // RW register storage; only i_Rst_L clears it, chip-select rise does not
    for (genvar k = 0; k < 8; k++) begin : g_reg
        if (k < NUM_RW) begin : g_rw
            logic [7:0] reg_q;
            // Register k captures the completed data byte when addressed
            always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    reg_q <= RESET_VAL;
                end else if (wr_en_s && (addr_q[2:0] == 3'(k))) begin
                    reg_q <= rx_byte_s;
                end
            end
            assign regs_s[k] = reg_q;
        end else begin : g_unused
            assign regs_s[k] = 8'h00;
        end
        assign o_Regs[8*k +: 8] = regs_s[k];
    end

    // Last written address survives frame boundaries
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_addr_q <= 4'd0;
        end else if (wr_en_s) begin
            wr_addr_q <= addr_q;
        end
    end

    // Frame FSM: CS_n rise is an asynchronous frame clear, distinct from reset
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            state_q  <= ST_CMD;
            cnt_q    <= 3'd0;
            addr_q   <= 4'd0;
            shift_q  <= 7'd0;
            tx_q     <= 7'd0;
            miso_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else if (i_SPI_CS_n) begin
            state_q  <= ST_CMD;
            cnt_q    <= 3'd0;
            shift_q  <= 7'd0;
            tx_q     <= 7'd0;
            miso_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + 3'd1;
            shift_q  <= rx_byte_s[6:0];
            strobe_q <= 1'b0;
            case (state_q)
                ST_CMD: begin
                    if (byte_done_s) begin
                        addr_q <= rx_byte_s[3:0];
                        if (rx_byte_s[7]) begin
                            state_q <= ST_READ;
                            miso_q  <= rd_val_s[7];
                            tx_q    <= rd_val_s[6:0];
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (byte_done_s) begin
                        strobe_q <= wr_en_s;
                        addr_q   <= addr_q + 4'd1;
                    end
                end
                ST_READ: begin
                    // MISO runs one edge ahead: byte completion preloads the next byte's MSB
                    if (byte_done_s) begin
                        addr_q <= rd_addr_s;
                        miso_q <= rd_val_s[7];
                        tx_q   <= rd_val_s[6:0];
                    end else begin
                        miso_q <= tx_q[6];
                        tx_q   <= {tx_q[5:0], 1'b0};
                    end
                end
                default: begin
                    state_q <= ST_CMD;
                end
            endcase
        end
    end

    assign o_SPI_MISO  = miso_q & ~i_SPI_CS_n;
    assign o_Wr_Strobe = strobe_q;
    assign o_Wr_Addr   = wr_addr_q;

endmodule
